// File: rtl/rtc_calendar.sv
// Binary year/month/day/hour/minute/second calendar with a second prescaler,
// validated time-set port and one-cycle strobes. Define RTC_LEAP_YEAR_EN for Gregorian February.
module rtc_calendar #(
  parameter int unsigned DIV_CONST  = 50_000_000,
  parameter int unsigned DIV_WIDTH  = 26,
  parameter int unsigned YEAR_WIDTH = 12,
  parameter int unsigned YEAR_RESET = 2000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_run,
  input  logic                  i_load,
  input  logic [YEAR_WIDTH-1:0] i_ld_year,
  input  logic [3:0]            i_ld_month,
  input  logic [4:0]            i_ld_day,
  input  logic [4:0]            i_ld_hour,
  input  logic [5:0]            i_ld_min,
  input  logic [5:0]            i_ld_sec,
  output logic [YEAR_WIDTH-1:0] o_year,
  output logic [3:0]            o_month,
  output logic [4:0]            o_day,
  output logic [4:0]            o_hour,
  output logic [5:0]            o_min,
  output logic [5:0]            o_sec,
  output logic                  o_sec_tick,
  output logic                  o_day_tick,
  output logic                  o_load_err
);

`ifdef RTC_LEAP_YEAR_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_CONST - 1);

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [YEAR_WIDTH-1:0] y);
    logic leap;
    leap = LEAP_EN && (y[1:0] == 2'b00) &&
           (((int'(y) % 100) != 0) || ((int'(y) % 400) == 0));
    case (m)
      4'd2:                      days_in_month = 5'd28 + {4'd0, leap};
      4'd4, 4'd6, 4'd9, 4'd11:   days_in_month = 5'd30;
      default:                   days_in_month = 5'd31;
    endcase
  endfunction

  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [YEAR_WIDTH-1:0] year_q, year_d;
  logic [3:0]            month_q, month_d;
  logic [4:0]            day_q, day_d, hour_q, hour_d;
  logic [5:0]            min_q, min_d, sec_q, sec_d;
  logic                  stick_q, stick_d, dtick_q, dtick_d, err_q, err_d;
  logic                  ld_ok;

  assign ld_ok = (i_ld_month >= 4'd1) && (i_ld_month <= 4'd12) &&
                 (i_ld_day >= 5'd1) && (i_ld_day <= days_in_month(i_ld_month, i_ld_year)) &&
                 (i_ld_hour < 5'd24) && (i_ld_min < 6'd60) && (i_ld_sec < 6'd60);

  always_comb begin
    div_d   = div_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    stick_d = 1'b0;
    dtick_d = 1'b0;
    err_d   = 1'b0;
    // A load request owns the cycle: any coincident advance is dropped.
    if (i_load) begin
      if (ld_ok) begin
        year_d  = i_ld_year;
        month_d = i_ld_month;
        day_d   = i_ld_day;
        hour_d  = i_ld_hour;
        min_d   = i_ld_min;
        sec_d   = i_ld_sec;
        div_d   = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (i_run) begin
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        stick_d = 1'b1;
        if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
        else begin
          sec_d = '0;
          if (min_q != 6'd59) min_d = min_q + 6'd1;
          else begin
            min_d = '0;
            if (hour_q != 5'd23) hour_d = hour_q + 5'd1;
            else begin
              hour_d  = '0;
              dtick_d = 1'b1;
              if (day_q != days_in_month(month_q, year_q)) day_d = day_q + 5'd1;
              else begin
                day_d = 5'd1;
                if (month_q != 4'd12) month_d = month_q + 4'd1;
                else begin
                  month_d = 4'd1;
                  year_d  = year_q + 1'b1;
                end
              end
            end
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q   <= '0;
      year_q  <= YEAR_WIDTH'(YEAR_RESET);
      month_q <= 4'd1;
      day_q   <= 5'd1;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      stick_q <= 1'b0;
      dtick_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      stick_q <= stick_d;
      dtick_q <= dtick_d;
      err_q   <= err_d;
    end
  end

  assign o_year     = year_q;
  assign o_month    = month_q;
  assign o_day      = day_q;
  assign o_hour     = hour_q;
  assign o_min      = min_q;
  assign o_sec      = sec_q;
  assign o_sec_tick = stick_q;
  assign o_day_tick = dtick_q;
  assign o_load_err = err_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Scoreboard bench for rtc_calendar: a seconds-of-day reference model predicts each
// cycle's registered outputs; a monitor compares them one cycle after each stimulus.
module tb_rtc_calendar;
  localparam int DIV = 4;
  localparam int YW  = 12;

  logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0, load = 1'b0;
  logic [YW-1:0] ld_year = '0;
  logic [3:0]    ld_month = '0;
  logic [4:0]    ld_day = '0, ld_hour = '0;
  logic [5:0]    ld_min = '0, ld_sec = '0;
  logic [YW-1:0] year;
  logic [3:0]    month;
  logic [4:0]    day, hour;
  logic [5:0]    mins, secs;
  logic          sec_tick, day_tick, load_err;

  rtc_calendar #(.DIV_CONST(DIV), .DIV_WIDTH(3), .YEAR_WIDTH(YW), .YEAR_RESET(2000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_load(load),
    .i_ld_year(ld_year), .i_ld_month(ld_month), .i_ld_day(ld_day),
    .i_ld_hour(ld_hour), .i_ld_min(ld_min), .i_ld_sec(ld_sec),
    .o_year(year), .o_month(month), .o_day(day), .o_hour(hour), .o_min(mins), .o_sec(secs),
    .o_sec_tick(sec_tick), .o_day_tick(day_tick), .o_load_err(load_err));

  always #5 clk = ~clk;

  typedef struct { int y, mo, d, h, mi, s, st, dt, er; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int my = 2000, mmo = 1, md = 1, msod = 0, mpre = 0;

  function automatic int dim(input int mo, input int y);
    int len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int r;
    r = len[mo-1];
`ifdef RTC_LEAP_YEAR_EN
    if (mo == 2 && y % 4 == 0 && (y % 100 != 0 || y % 400 == 0)) r = 29;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("year", int'(year), e.y);   chk("month", int'(month), e.mo);
    chk("day", int'(day), e.d);     chk("hour", int'(hour), e.h);
    chk("min", int'(mins), e.mi);   chk("sec", int'(secs), e.s);
    chk("sec_tick", int'(sec_tick), e.st);
    chk("day_tick", int'(day_tick), e.dt);
    chk("load_err", int'(load_err), e.er);
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after the next edge.
  task automatic cyc(input bit r, input bit l, input int y, mo, d, h, mi, s);
    exp_t e;
    bit ok;
    @(negedge clk);
    run = r; load = l;
    ld_year = YW'(y); ld_month = 4'(mo); ld_day = 5'(d);
    ld_hour = 5'(h); ld_min = 6'(mi); ld_sec = 6'(s);
    e.st = 0; e.dt = 0; e.er = 0;
    if (l) begin
      ok = mo >= 1 && mo <= 12 && h < 24 && mi < 60 && s < 60;
      if (ok) ok = d >= 1 && d <= dim(mo, y);
      if (ok) begin
        my = y; mmo = mo; md = d; msod = h * 3600 + mi * 60 + s; mpre = 0;
      end else e.er = 1;
    end else if (r) begin
      if (mpre == DIV - 1) begin
        mpre = 0; e.st = 1; msod++;
        if (msod == 86400) begin
          msod = 0; e.dt = 1; md++;
          if (md > dim(mmo, my)) begin
            md = 1; mmo++;
            if (mmo > 12) begin mmo = 1; my = (my + 1) % 4096; end
          end
        end
      end else mpre++;
    end
    e.y = my; e.mo = mmo; e.d = md;
    e.h = msod / 3600; e.mi = (msod / 60) % 60; e.s = msod % 60;
    q.push_back(e);
  endtask

  task automatic idle(input bit r, input int n);
    for (int i = 0; i < n; i++) cyc(r, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) chk_all(q.pop_front());
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int years [6] = '{1900, 2000, 2023, 2024, 2100, 4095};
    exp_t rst_e;
    rst_e = '{y: 2000, mo: 1, d: 1, h: 0, mi: 0, s: 0, st: 0, dt: 0, er: 0};
    #12;
    chk_all(rst_e);
    @(negedge clk) rst_n = 1'b1;

    idle(1, 6);                                   // first tick lands on the 4th output
    cyc(0, 1, 2023, 12, 31, 23, 59, 59); idle(1, 4);
    cyc(0, 1, 2024, 2, 28, 23, 59, 59);  idle(1, 4);
    cyc(0, 1, 2100, 2, 28, 23, 59, 59);  idle(1, 4);
    cyc(1, 1, 2023, 2, 29, 12, 0, 0);    idle(1, 2);
    cyc(1, 1, 2023, 5, 10, 24, 0, 0);    idle(1, 2);
    cyc(0, 1, 4095, 12, 31, 23, 59, 59); idle(1, 4);
    cyc(1, 1, 2024, 6, 1, 10, 0, 0);     idle(1, 3);
    cyc(1, 1, 2025, 7, 4, 8, 30, 15);    idle(1, 5);   // load on terminal count
    idle(1, 2);
    idle(0, 20);
    cyc(0, 1, 2023, 3, 15, 1, 2, 3);     idle(0, 20);  // loads accepted while stopped
    idle(1, 10);

    for (int i = 0; i < 3000; i++) begin
      bit r, l;
      int y, mo, d, h, mi, s;
      r  = $urandom_range(0, 9) != 0;
      l  = $urandom_range(0, 15) == 0;
      y  = $urandom_range(0, 1) ? int'($urandom_range(0, 4095)) : years[$urandom_range(0, 5)];
      mo = $urandom_range(0, 13);
      d  = $urandom_range(0, 1) ? int'($urandom_range(27, 31)) : int'($urandom_range(0, 31));
      h  = $urandom_range(20, 24);
      mi = $urandom_range(55, 60);
      s  = $urandom_range(50, 60);
      cyc(r, l, y, mo, d, h, mi, s);
    end
    idle(1, 1);
    @(negedge clk);
    @(negedge clk);

    #2 rst_n = 1'b0;                              // asynchronous reset mid-cycle
    #1 chk_all(rst_e);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
